// File: rtl/silent_lpf_v3_if.sv
// -----------------------------------------------------------------------------
// silent_lpf_v3_if
// Bundles the control, target and slewed-output signals of the silent-mode
// slew limiter so the operation stage (master) and the limiter (slave) share
// one port.
//   enable      : 1 = slew-limited update, 0 = bypass (outputs take targets)
//   start       : level; a 0->1 change between clock samples begins a pass
//   step_duty   : maximum duty change per pass
//   step_phase  : maximum phase change per pass
//   cycle[i]    : per-channel period in PWM ticks
//   duty[i]     : target duty
//   phase[i]    : target phase
//   duty_s[i]   : slewed duty
//   phase_s[i]  : slewed phase
//   busy        : high while a pass is in progress
//   done        : one-cycle pulse when a pass completes
// -----------------------------------------------------------------------------
interface silent_lpf_v3_if #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
);
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] step_duty;
  logic [WIDTH-1:0] step_phase;
  logic [WIDTH-1:0] cycle   [0:DEPTH-1];
  logic [WIDTH-1:0] duty    [0:DEPTH-1];
  logic [WIDTH-1:0] phase   [0:DEPTH-1];
  logic [WIDTH-1:0] duty_s  [0:DEPTH-1];
  logic [WIDTH-1:0] phase_s [0:DEPTH-1];
  logic             busy;
  logic             done;

  modport master (
    output enable, start, step_duty, step_phase, cycle, duty, phase,
    input  duty_s, phase_s, busy, done
  );

  modport slave (
    input  enable, start, step_duty, step_phase, cycle, duty, phase,
    output duty_s, phase_s, busy, done
  );
endinterface

// File: rtl/silent_lpf_v3.sv
// -----------------------------------------------------------------------------
// silent_lpf_v3
// Per-transducer slew limiter. After each start edge one shared two-stage
// datapath walks every channel in order and moves its duty and phase toward
// the target by at most the programmed step. Phase moves along the shorter
// way round the circle of length cycle[i].
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : silent_lpf_v3_if slave modport (controls, targets, outputs)
// Timing: with the start edge visible in cycle 0, channel i is written into
// cycle i+2, done pulses in cycle DEPTH+2 and busy covers cycles 1..DEPTH+2.
// -----------------------------------------------------------------------------
module silent_lpf_v3 #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic             clk,
  input  logic             rst_n,
  silent_lpf_v3_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_prev_q, start_prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             issue;
  logic             start_edge;

  logic             s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s1_enable_q, s1_enable_d;
  logic [WIDTH-1:0] s1_cycle_q, s1_cycle_d;
  logic [WIDTH-1:0] s1_duty_q, s1_duty_d;
  logic [WIDTH-1:0] s1_phase_q, s1_phase_d;
  logic [WIDTH-1:0] s1_duty_s_q, s1_duty_s_d;
  logic [WIDTH-1:0] s1_phase_s_q, s1_phase_s_d;
  logic [WIDTH-1:0] s1_step_duty_q, s1_step_duty_d;
  logic [WIDTH-1:0] s1_step_phase_q, s1_step_phase_d;

  logic [WIDTH-1:0] duty_s_q  [0:DEPTH-1];
  logic [WIDTH-1:0] duty_s_d  [0:DEPTH-1];
  logic [WIDTH-1:0] phase_s_q [0:DEPTH-1];
  logic [WIDTH-1:0] phase_s_d [0:DEPTH-1];

  logic [WIDTH-1:0]      divisor;
  logic [WIDTH-1:0]      duty_t;
  logic [WIDTH-1:0]      phase_t;
  logic [WIDTH-1:0]      ps_base;
  logic [WIDTH-1:0]      half;
  logic [WIDTH-1:0]      fwd;
  logic [WIDTH-1:0]      bwd;
  logic [WIDTH-1:0]      mv;
  logic signed [WIDTH:0] duty_diff;
  logic signed [WIDTH:0] step_d_s;
  logic signed [WIDTH:0] ph_diff;
  logic signed [WIDTH:0] ph_dec;
  logic [WIDTH:0]        ph_sum;
  logic [WIDTH-1:0]      duty_new;
  logic [WIDTH-1:0]      phase_new;

  // A start edge that lands while busy is still high is dropped, not queued.
  assign start_edge = bus.start & ~start_prev_q;

  // Pass sequencer: channel 0 is issued on the same edge that accepts start,
  // so the walk begins immediately; DRAIN waits for stage 2 to retire.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    issue        = 1'b0;
    start_prev_d = bus.start;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        idx_d  = '0;
        if (start_edge && !busy_q) begin
          issue  = 1'b1;
          busy_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      RUN: begin
        issue = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (!s1_valid_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 capture: targets, steps and current outputs are sampled only when
  // the channel is issued, so later input changes affect later channels only.
  always_comb begin
    s1_valid_d      = issue;
    s1_idx_d        = s1_idx_q;
    s1_enable_d     = s1_enable_q;
    s1_cycle_d      = s1_cycle_q;
    s1_duty_d       = s1_duty_q;
    s1_phase_d      = s1_phase_q;
    s1_duty_s_d     = s1_duty_s_q;
    s1_phase_s_d    = s1_phase_s_q;
    s1_step_duty_d  = s1_step_duty_q;
    s1_step_phase_d = s1_step_phase_q;
    if (issue) begin
      s1_idx_d        = idx_q;
      s1_enable_d     = bus.enable;
      s1_cycle_d      = bus.cycle[idx_q];
      s1_duty_d       = bus.duty[idx_q];
      s1_phase_d      = bus.phase[idx_q];
      s1_duty_s_d     = duty_s_q[idx_q];
      s1_phase_s_d    = phase_s_q[idx_q];
      s1_step_duty_d  = bus.step_duty;
      s1_step_phase_d = bus.step_phase;
    end
  end

  // Stage 2 arithmetic. The divisor is forced to 1 for a zero cycle only to
  // keep the modulo defined; that channel's result is overridden to 0 anyway.
  always_comb begin
    divisor   = (s1_cycle_q == '0) ? WIDTH'(1) : s1_cycle_q;
    duty_t    = (s1_duty_q > s1_cycle_q) ? s1_cycle_q : s1_duty_q;
    phase_t   = s1_phase_q % divisor;
    ps_base   = s1_phase_s_q % divisor;
    half      = divisor >> 1;

    duty_diff = $signed({1'b0, duty_t}) - $signed({1'b0, s1_duty_s_q});
    step_d_s  = $signed({1'b0, s1_step_duty_q});
    if (duty_diff > step_d_s) begin
      duty_new = s1_duty_s_q + s1_step_duty_q;
    end else if (duty_diff < -step_d_s) begin
      duty_new = s1_duty_s_q - s1_step_duty_q;
    end else begin
      duty_new = duty_t;
    end

    // fwd is the distance going up (mod cycle), bwd the distance going down.
    ph_diff = $signed({1'b0, phase_t}) - $signed({1'b0, ps_base});
    if (ph_diff[WIDTH]) begin
      ph_diff = ph_diff + $signed({1'b0, divisor});
    end
    fwd    = ph_diff[WIDTH-1:0];
    bwd    = divisor - fwd;
    mv     = '0;
    ph_sum = '0;
    ph_dec = '0;
    if (fwd == '0) begin
      phase_new = ps_base;
    end else if (fwd <= half) begin
      mv     = (s1_step_phase_q < fwd) ? s1_step_phase_q : fwd;
      ph_sum = {1'b0, ps_base} + {1'b0, mv};
      if (ph_sum >= {1'b0, divisor}) begin
        ph_sum = ph_sum - {1'b0, divisor};
      end
      phase_new = ph_sum[WIDTH-1:0];
    end else begin
      mv     = (s1_step_phase_q < bwd) ? s1_step_phase_q : bwd;
      ph_dec = $signed({1'b0, ps_base}) - $signed({1'b0, mv});
      if (ph_dec[WIDTH]) begin
        ph_dec = ph_dec + $signed({1'b0, divisor});
      end
      phase_new = ph_dec[WIDTH-1:0];
    end

    if (!s1_enable_q) begin
      duty_new  = duty_t;
      phase_new = phase_t;
    end
    if (s1_cycle_q == '0) begin
      duty_new  = '0;
      phase_new = '0;
    end
  end

  // Write-back of the retiring channel into the output arrays.
  always_comb begin
    duty_s_d  = duty_s_q;
    phase_s_d = phase_s_q;
    if (s1_valid_q) begin
      duty_s_d[s1_idx_q]  = duty_new;
      phase_s_d[s1_idx_q] = phase_new;
    end
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      start_prev_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_idx_q        <= '0;
      s1_enable_q     <= 1'b0;
      s1_cycle_q      <= '0;
      s1_duty_q       <= '0;
      s1_phase_q      <= '0;
      s1_duty_s_q     <= '0;
      s1_phase_s_q    <= '0;
      s1_step_duty_q  <= '0;
      s1_step_phase_q <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      start_prev_q    <= start_prev_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      s1_valid_q      <= s1_valid_d;
      s1_idx_q        <= s1_idx_d;
      s1_enable_q     <= s1_enable_d;
      s1_cycle_q      <= s1_cycle_d;
      s1_duty_q       <= s1_duty_d;
      s1_phase_q      <= s1_phase_d;
      s1_duty_s_q     <= s1_duty_s_d;
      s1_phase_s_q    <= s1_phase_s_d;
      s1_step_duty_q  <= s1_step_duty_d;
      s1_step_phase_q <= s1_step_phase_d;
    end
  end

  // Output arrays; a reset mid-pass leaves unwritten channels at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        duty_s_q[i]  <= '0;
        phase_s_q[i] <= '0;
      end
    end else begin
      duty_s_q  <= duty_s_d;
      phase_s_q <= phase_s_d;
    end
  end

  assign bus.duty_s  = duty_s_q;
  assign bus.phase_s = phase_s_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_silent_lpf_v3.sv
// -----------------------------------------------------------------------------
// tb_silent_lpf_v3
// Self-checking bench for silent_lpf_v3: directed scenarios plus randomized
// targets compared against an arithmetic model of the slew rules.
// -----------------------------------------------------------------------------
module tb_silent_lpf_v3;

  localparam int WIDTH = 13;
  localparam int DEPTH = 249;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  silent_lpf_v3_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  silent_lpf_v3 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_duty  [DEPTH];
  int m_phase [DEPTH];

  // Reference duty rule: clamp to the period, then step toward it.
  function automatic int slew_duty(int cur, int tgt, int cyc, int step, bit en);
    int t;
    if (cyc == 0) return 0;
    t = (tgt > cyc) ? cyc : tgt;
    if (!en) return t;
    if (t > cur + step) return cur + step;
    if (t < cur - step) return cur - step;
    return t;
  endfunction

  // Reference phase rule: step along the shorter arc of the circle.
  function automatic int slew_phase(int cur, int tgt, int cyc, int step, bit en);
    int t, base, up, down, mv;
    if (cyc == 0) return 0;
    t = tgt % cyc;
    if (!en) return t;
    base = cur % cyc;
    up   = (t - base + cyc) % cyc;
    down = (base - t + cyc) % cyc;
    if (up == 0) return base;
    if (up <= cyc / 2) begin
      mv = (step < up) ? step : up;
      return (base + mv) % cyc;
    end
    mv = (step < down) ? step : down;
    return (base - mv + cyc) % cyc;
  endfunction

  task automatic model_pass();
    for (int i = 0; i < DEPTH; i++) begin
      m_duty[i]  = slew_duty(m_duty[i], int'(bus.duty[i]), int'(bus.cycle[i]),
                             int'(bus.step_duty), bus.enable);
      m_phase[i] = slew_phase(m_phase[i], int'(bus.phase[i]), int'(bus.cycle[i]),
                              int'(bus.step_phase), bus.enable);
    end
  endtask

  task automatic set_all(int cyc, int d, int p);
    for (int i = 0; i < DEPTH; i++) begin
      bus.cycle[i] = WIDTH'(cyc);
      bus.duty[i]  = WIDTH'(d);
      bus.phase[i] = WIDTH'(p);
    end
  endtask

  task automatic apply_reset();
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m_duty[i]  = 0;
      m_phase[i] = 0;
    end
  endtask

  // One full pass with a bounded wait on done, then the model follows.
  task automatic run_pass();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 0; n < DEPTH + 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL pass_timeout done=0 required=1");
    end
    model_pass();
  endtask

  task automatic test_reset();
    int nz;
    bus.enable     = 1'b1;
    bus.start      = 1'b0;
    bus.step_duty  = '0;
    bus.step_phase = '0;
    set_all(5000, 0, 0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nz = 0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.duty_s[i] !== '0 || bus.phase_s[i] !== '0) nz++;
    total++;
    if (nz !== 0) begin
      bad++;
      $display("[TB] FAIL reset_outputs nonzero_channels=%0d required=0", nz);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags busy=%b done=%b required=0/0", bus.busy, bus.done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m_duty[i]  = 0;
      m_phase[i] = 0;
    end
  endtask

  task automatic test_latency();
    int busy_cycles, first_busy, done_at, done_cnt;
    bus.step_duty     = WIDTH'(100);
    bus.duty[0]       = WIDTH'(50);
    bus.duty[DEPTH-1] = WIDTH'(70);
    busy_cycles = 0;
    first_busy  = -1;
    done_at     = -1;
    done_cnt    = 0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_busy busy=%b required=0", bus.busy);
    end
    bus.start = 1'b1;
    for (int n = 1; n <= DEPTH + 6; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        busy_cycles++;
        if (first_busy < 0) first_busy = n;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = n;
      end
      if (n == 1 || n == 2) begin
        total++;
        if (bus.duty_s[0] !== WIDTH'(n == 1 ? 0 : 50)) begin
          bad++;
          $display("[TB] FAIL ch0_write_cycle cycle=%0d duty_s=%0d required=%0d",
                   n, bus.duty_s[0], (n == 1 ? 0 : 50));
        end
      end
      if (n == DEPTH || n == DEPTH + 1) begin
        total++;
        if (bus.duty_s[DEPTH-1] !== WIDTH'(n == DEPTH ? 0 : 70)) begin
          bad++;
          $display("[TB] FAIL last_write_cycle cycle=%0d duty_s=%0d required=%0d",
                   n, bus.duty_s[DEPTH-1], (n == DEPTH ? 0 : 70));
        end
      end
    end
    bus.start = 1'b0;
    total++;
    if (done_at !== DEPTH + 2 || done_cnt !== 1) begin
      bad++;
      $display("[TB] FAIL done_latency cycle=%0d pulses=%0d required=%0d/1",
               done_at, done_cnt, DEPTH + 2);
    end
    total++;
    if (busy_cycles !== DEPTH + 2 || first_busy !== 1) begin
      bad++;
      $display("[TB] FAIL busy_window cycles=%0d first=%0d required=%0d/1",
               busy_cycles, first_busy, DEPTH + 2);
    end
    model_pass();
  endtask

  task automatic test_duty_ramp();
    int exp;
    apply_reset();
    set_all(5000, 0, 0);
    bus.enable     = 1'b1;
    bus.step_duty  = WIDTH'(100);
    bus.step_phase = '0;
    bus.duty[0]    = WIDTH'(2550);
    for (int k = 1; k <= 28; k++) begin
      run_pass();
      exp = (100 * k < 2550) ? 100 * k : 2550;
      total++;
      if (bus.duty_s[0] !== WIDTH'(exp)) begin
        bad++;
        $display("[TB] FAIL duty_ramp pass=%0d duty_s=%0d required=%0d",
                 k, bus.duty_s[0], exp);
      end
    end
  endtask

  task automatic test_phase_wrap();
    int exp_list [3];
    exp_list = '{4950, 4900, 4900};
    apply_reset();
    set_all(5000, 0, 0);
    bus.enable     = 1'b0;
    bus.step_duty  = '0;
    bus.step_phase = '0;
    bus.phase[0]   = WIDTH'(100);
    run_pass();
    total++;
    if (bus.phase_s[0] !== WIDTH'(100)) begin
      bad++;
      $display("[TB] FAIL phase_preset phase_s=%0d required=100", bus.phase_s[0]);
    end
    bus.enable     = 1'b1;
    bus.phase[0]   = WIDTH'(4900);
    bus.step_phase = WIDTH'(150);
    for (int k = 0; k < 3; k++) begin
      run_pass();
      total++;
      if (bus.phase_s[0] !== WIDTH'(exp_list[k])) begin
        bad++;
        $display("[TB] FAIL phase_wrap pass=%0d phase_s=%0d required=%0d",
                 k + 1, bus.phase_s[0], exp_list[k]);
      end
    end
  endtask

  task automatic test_bypass();
    bus.enable     = 1'b0;
    bus.step_duty  = WIDTH'(1);
    bus.step_phase = WIDTH'(1);
    bus.cycle[3] = WIDTH'(5000); bus.duty[3] = WIDTH'(6000); bus.phase[3] = WIDTH'(7000);
    bus.cycle[4] = WIDTH'(0);    bus.duty[4] = WIDTH'(100);  bus.phase[4] = WIDTH'(200);
    bus.cycle[5] = WIDTH'(5000); bus.duty[5] = WIDTH'(1234); bus.phase[5] = WIDTH'(321);
    run_pass();
    total++;
    if (bus.duty_s[3] !== WIDTH'(5000) || bus.phase_s[3] !== WIDTH'(2000)) begin
      bad++;
      $display("[TB] FAIL bypass_clamp duty_s=%0d phase_s=%0d required=5000/2000",
               bus.duty_s[3], bus.phase_s[3]);
    end
    total++;
    if (bus.duty_s[4] !== '0 || bus.phase_s[4] !== '0) begin
      bad++;
      $display("[TB] FAIL zero_cycle duty_s=%0d phase_s=%0d required=0/0",
               bus.duty_s[4], bus.phase_s[4]);
    end
    total++;
    if (bus.duty_s[5] !== WIDTH'(1234) || bus.phase_s[5] !== WIDTH'(321)) begin
      bad++;
      $display("[TB] FAIL bypass_direct duty_s=%0d phase_s=%0d required=1234/321",
               bus.duty_s[5], bus.phase_s[5]);
    end
    bus.cycle[4] = WIDTH'(5000);
  endtask

  task automatic test_busy_ignore();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 1; n <= 2 * DEPTH + 20; n++) begin
      @(negedge clk);
      if (n == 20) bus.start = 1'b0;
      if (n == 25) bus.start = 1'b1;
      if (bus.done === 1'b1) done_cnt++;
    end
    bus.start = 1'b0;
    model_pass();
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("[TB] FAIL busy_ignore done_pulses=%0d required=1", done_cnt);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_ignore_idle busy=%b required=0", bus.busy);
    end
    run_pass();
  endtask

  task automatic test_random();
    int errs, first;
    apply_reset();
    bus.enable     = 1'b1;
    bus.step_duty  = WIDTH'(100);
    bus.step_phase = WIDTH'(100);
    for (int i = 0; i < DEPTH; i++) begin
      bus.cycle[i] = WIDTH'(5000);
      bus.duty[i]  = WIDTH'($urandom_range(0, 8191));
      bus.phase[i] = WIDTH'($urandom_range(0, 8191));
    end
    for (int k = 1; k <= 55; k++) begin
      run_pass();
      errs  = 0;
      first = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.duty_s[i] !== WIDTH'(m_duty[i]) || bus.phase_s[i] !== WIDTH'(m_phase[i])) begin
          errs++;
          if (first < 0) first = i;
        end
      end
      total++;
      if (errs !== 0) begin
        bad++;
        $display("[TB] FAIL random_pass pass=%0d ch=%0d duty_s=%0d phase_s=%0d required=%0d/%0d",
                 k, first, bus.duty_s[first], bus.phase_s[first], m_duty[first], m_phase[first]);
      end
    end
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.duty_s[i] !== WIDTH'((int'(bus.duty[i]) > 5000) ? 5000 : int'(bus.duty[i])) ||
          bus.phase_s[i] !== WIDTH'(int'(bus.phase[i]) % 5000))
        errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL random_converged channels_off=%0d required=0", errs);
    end
  endtask

  task automatic test_step_zero();
    int hold_d [DEPTH];
    int hold_p [DEPTH];
    int errs;
    for (int i = 0; i < DEPTH; i++) begin
      hold_d[i]    = m_duty[i];
      hold_p[i]    = m_phase[i];
      bus.duty[i]  = WIDTH'($urandom_range(0, 8191));
      bus.phase[i] = WIDTH'($urandom_range(0, 8191));
    end
    bus.step_duty  = '0;
    bus.step_phase = '0;
    run_pass();
    errs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.duty_s[i] !== WIDTH'(hold_d[i]) || bus.phase_s[i] !== WIDTH'(hold_p[i])) errs++;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL step_zero_hold channels_moved=%0d required=0", errs);
    end
  endtask

  task automatic test_mid_reset();
    int nz;
    bus.step_duty  = WIDTH'(100);
    bus.step_phase = WIDTH'(100);
    @(negedge clk);
    bus.start = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.duty_s[i] !== '0 || bus.phase_s[i] !== '0) nz++;
    total++;
    if (nz !== 0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs nonzero_channels=%0d required=0", nz);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_flags busy=%b done=%b required=0/0", bus.busy, bus.done);
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_duty_ramp();
    test_phase_wrap();
    test_bypass();
    test_busy_ignore();
    test_random();
    test_step_zero();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
